// File: rtl/add_sequencer_pkg.sv
// rtl/add_sequencer_pkg.sv - shared types and constants for the limb-serial adder
package add_sequencer_pkg;

  localparam int LIMB_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow: operands agree in sign, result sign differs
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/prefix_adder_16bit.sv
// rtl/prefix_adder_16bit.sv - 16-bit Kogge-Stone prefix adder with carry in
module prefix_adder_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [15:0] p0;
  logic [15:0] g0;
  logic [15:0] g1, p1;
  logic [15:0] g2, p2;
  logic [15:0] g3, p3;
  logic [15:0] g4;

  // Carry-in is folded into bit 0's generate so every prefix group reaches it
  assign p0 = A ^ B;
  assign g0 = {A[15:1] & B[15:1], (A[0] & B[0]) | (p0[0] & Cin)};

  // Four prefix levels with spans 1, 2, 4, 8; zero fill keeps low groups final
  assign g1 = g0 | (p0 & (g0 << 1));
  assign p1 = p0 & (p0 << 1);
  assign g2 = g1 | (p1 & (g1 << 2));
  assign p2 = p1 & (p1 << 2);
  assign g3 = g2 | (p2 & (g2 << 4));
  assign p3 = p2 & (p2 << 4);
  assign g4 = g3 | (p3 & (g3 << 8));

  // Carry into bit i is the group generate of bits i-1..0
  assign S    = p0 ^ {g4[14:0], Cin};
  assign Cout = g4[15];

endmodule

// File: rtl/add_sequencer.sv
// rtl/add_sequencer.sv - multi-limb add/subtract through one shared 16-bit adder
module add_sequencer
  import add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LIMB_W*WORDS-1:0]   a,
  input  logic [LIMB_W*WORDS-1:0]   b,
  input  logic                      sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LIMB_W*WORDS-1:0]   sum,
  output logic                      cout,
  output logic                      ovf
);

  localparam int W = LIMB_W * WORDS;
  localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

  state_t            state;
  logic [2:0]        idx;
  logic              carry;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic [LIMB_W-1:0] a_limb;
  logic [LIMB_W-1:0] b_limb;
  logic [LIMB_W-1:0] add_s;
  logic              add_cout;

  // Accept only when idle and out of reset; first cycle after release is ready
  assign in_ready = (state == IDLE) && !rst;
  assign sum      = sum_q;

  // Limb select for the shared adder, steered by the limb index register
  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == 3'(k)) begin
        a_limb = a_q[k*LIMB_W +: LIMB_W];
        b_limb = b_q[k*LIMB_W +: LIMB_W];
      end
    end
  end

  prefix_adder_16bit u_adder (
    .A    (a_limb),
    .B    (b_limb),
    .Cin  (carry),
    .S    (add_s),
    .Cout (add_cout)
  );

  // Control FSM: capture operands, step one limb per RUN cycle, hold result in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx == 3'(k)) begin
              sum_q[k*LIMB_W +: LIMB_W] <= add_s;
            end
          end
          carry <= add_cout;
          idx   <= idx + 3'd1;
          if (idx == LAST_IDX) begin
            cout      <= add_cout;
            ovf       <= signed_ovf(a_q[W-1], b_q[W-1], add_s[LIMB_W-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// tb/tb_add_sequencer.sv - scoreboard bench for add_sequencer with WORDS=4
module tb_add_sequencer;

  localparam int WORDS = 4;
  localparam int W = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;
  int   last_acc = -100;
  int   last_hs = -100;
  int   acc_count = 0;
  logic ov_prev = 1'b0;

  always #5 clk = ~clk;

  add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Edge bookkeeping: which rising edge accepted an operation or completed a handshake
  always @(posedge clk) begin
    edge_cnt++;
    if (!rst && in_valid && in_ready) begin
      last_acc = edge_cnt;
      acc_count++;
    end
    if (!rst && out_valid && out_ready) last_hs = edge_cnt;
  end

  // Monitor: latency on out_valid rise, result compare on each handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !ov_prev) check("latency", 64'(edge_cnt - last_acc), 64'(WORDS));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.sum);
          check("cout", 64'(cout), 64'(e.cout));
          check("ovf", 64'(ovf), 64'(e.ovf));
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    exp_q.push_back(exp_t'{es, ec, eo});
    a = ta;
    b = tb_v;
    sub = tsub;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int n;
    int ac;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", sum, 64'h0);
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'(1));

    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    issue(64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    issue(64'h5, 64'h5, 1'b1, 64'h0, 1'b1, 1'b0);
    wait_drain();

    // Backpressure in DONE with a new request waiting
    out_ready = 1'b0;
    issue(64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    a = 64'h10;
    b = 64'h20;
    sub = 1'b1;
    in_valid = 1'b1;
    ac = acc_count;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_sum", sum, 64'h7);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
    end
    check("bp_no_accept", 64'(acc_count), 64'(ac));
    exp_q.push_back(exp_t'{64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0});
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_after_hs", 64'(last_acc - last_hs), 64'(1));
    check("bp_one_accept", 64'(acc_count), 64'(ac + 1));
    wait_drain();

    // Abort in the second RUN cycle
    issue(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 64'h3333_3333_3333_3333, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'(0));
    check("abort_in_ready", 64'(in_ready), 64'(0));
    check("abort_sum", sum, 64'h0);
    check("abort_cout", 64'(cout), 64'(0));
    check("abort_ovf", 64'(ovf), 64'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_in_ready_release", 64'(in_ready), 64'(1));
    issue(64'h1234, 64'h5678, 1'b0, 64'h68AC, 1'b0, 1'b0);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
